// File: rtl/dmem_arbiter_pkg.sv
// Shared rv32 definitions for the data-memory arbiter: FSM encoding and the
// default memory depth.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_DEPTH = 32'd100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_chk.sv
// Protocol checker: never both memory enables, never more than one grant.
module dmem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic mem_r_en,
  input logic mem_w_en,
  input logic m0_gnt,
  input logic m1_gnt
);

  a_mem_en_excl: assert property (@(posedge clk) disable iff (!rst)
    !(mem_r_en && mem_w_en));

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({m1_gnt, m0_gnt}));

endmodule

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-port round-robin selector: the port not granted last wins a contention.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // last=1 means port 1 was granted last, so port 0 has priority
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory; one access
// every three cycles, out-of-range addresses answered with an error.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rsp_valid,
  output logic        m1_rsp_valid,
  output logic        m0_rsp_err,
  output logic        m1_rsp_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_e  r_state;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic        r_err;
  logic [1:0]  r_rsp_valid;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic [1:0]  w_arb_gnt;
  logic [1:0]  w_gnt;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_oor;
  logic [31:0] w_rd_data;

  rr_arb2 u_rr (
    .req   ({m1_req, m0_req}),
    .last  (r_last),
    .grant (w_arb_gnt)
  );

  // Grant is combinational and only offered while idle
  always_comb begin
    w_gnt       = 2'b00;
    w_sel_we    = 1'b0;
    w_sel_addr  = 32'd0;
    w_sel_wdata = 32'd0;
    if (r_state == ST_IDLE) begin
      w_gnt = w_arb_gnt;
    end else begin
      w_gnt = 2'b00;
    end
    if (w_gnt[1]) begin
      w_sel_we    = m1_we;
      w_sel_addr  = m1_addr;
      w_sel_wdata = m1_wdata;
    end else begin
      w_sel_we    = m0_we;
      w_sel_addr  = m0_addr;
      w_sel_wdata = m0_wdata;
    end
    w_oor = (w_sel_addr >= 32'(DEPTH));
  end

  // Arbiter FSM; memory address/data registers only load for an in-range issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_mem_r_en  <= 1'b0;
      r_mem_w_en  <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_r_en  <= 1'b0;
      r_mem_w_en  <= 1'b0;
      r_rsp_valid <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_owner <= w_gnt[1];
            r_last  <= w_gnt[1];
            r_we    <= w_sel_we;
            r_err   <= w_oor;
            if (w_oor) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= w_gnt;
            end else begin
              r_state     <= ST_ISSUE;
              r_mem_r_en  <= ~w_sel_we;
              r_mem_w_en  <= w_sel_we;
              r_mem_addr  <= w_sel_addr;
              r_mem_wdata <= w_sel_wdata;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= {r_owner, ~r_owner};
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data comes straight from memory in the response cycle
  always_comb begin
    if ((r_rsp_valid != 2'b00) && !r_we && !r_err) begin
      w_rd_data = mem_rdata;
    end else begin
      w_rd_data = 32'd0;
    end
  end

  assign m0_gnt       = w_gnt[0];
  assign m1_gnt       = w_gnt[1];
  assign m0_rsp_valid = r_rsp_valid[0];
  assign m1_rsp_valid = r_rsp_valid[1];
  assign m0_rsp_err   = r_rsp_valid[0] & r_err;
  assign m1_rsp_err   = r_rsp_valid[1] & r_err;
  assign m0_rdata     = r_rsp_valid[0] ? w_rd_data : 32'd0;
  assign m1_rdata     = r_rsp_valid[1] ? w_rd_data : 32'd0;
  assign mem_r_en     = r_mem_r_en;
  assign mem_w_en     = r_mem_w_en;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

  dmem_arbiter_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .m0_gnt   (m0_gnt),
    .m1_gnt   (m1_gnt)
  );

endmodule
